// File: rtl/control.sv
// control: Moore instruction-sequencing FSM for the Simple RISC Machine datapath.
// Waits for a start pulse, decodes opcode/op, then walks the datapath through
// operand reads, the ALU step, status update and register write-back.
// Outputs are registered: each edge loads the strobe pattern of the state being
// entered, so every output is a pure function of present_state.
`timescale 1ns/1ps
module control (
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       asel,
    output logic       bsel,
    output logic       loadc,
    output logic       loads,
    output logic [2:0] nsel,
    output logic       w
);

    typedef enum logic [4:0] {
        st_wait         = 5'd0,
        st_decode       = 5'd1,
        st_getb         = 5'd2,
        st_geta         = 5'd3,
        st_and_add      = 5'd4,
        st_mvn_mov      = 5'd5,
        st_getstatus    = 5'd6,
        st_result_to_rd = 5'd7,
        st_movim_to_rn  = 5'd8
    } state_t;

    typedef struct packed {
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic       loadc;
        logic       loads;
        logic [2:0] nsel;
        logic       w;
    } ctrl_t;

    localparam logic [2:0] OPC_MOVE = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CMP   = 2'b01;
    localparam logic [1:0] OP_AND   = 2'b10;
    localparam logic [1:0] OP_MVN   = 2'b11;
    localparam logic [1:0] OP_MOVR  = 2'b00;
    localparam logic [1:0] OP_MOVI  = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;

    state_t present_state;
    state_t next_state;
    ctrl_t  ctrl;

    // Strobe pattern asserted while sitting in a given state; anything not set is 0.
    function automatic ctrl_t ctrl_of(input state_t st);
        ctrl_t c;
        c = '0;
        case (st)
            st_wait: begin
                c.w = 1'b1;
            end
            st_geta: begin
                c.nsel  = NSEL_RN;
                c.loada = 1'b1;
            end
            st_getb: begin
                c.nsel  = NSEL_RM;
                c.loadb = 1'b1;
            end
            st_and_add: begin
                c.asel  = 1'b0;
                c.bsel  = 1'b0;
                c.loadc = 1'b1;
            end
            st_mvn_mov: begin
                // MOV Rd,Rm and MVN pass B through the ALU with A forced to zero
                c.asel  = 1'b1;
                c.bsel  = 1'b0;
                c.loadc = 1'b1;
            end
            st_getstatus: begin
                c.asel  = 1'b0;
                c.bsel  = 1'b0;
                c.loads = 1'b1;
            end
            st_result_to_rd: begin
                c.nsel  = NSEL_RD;
                c.vsel  = VSEL_C;
                c.write = 1'b1;
            end
            st_movim_to_rn: begin
                c.nsel  = NSEL_RN;
                c.vsel  = VSEL_IMM8;
                c.write = 1'b1;
            end
            default: begin
                c.nsel = NSEL_NONE;
            end
        endcase
        return c;
    endfunction

    // Next-state decode; opcode/op are held stable for the whole instruction.
    always_comb begin
        next_state = st_wait;
        case (present_state)
            st_wait: begin
                next_state = s ? st_decode : st_wait;
            end
            st_decode: begin
                if (opcode == OPC_MOVE && op == OP_MOVI)
                    next_state = st_movim_to_rn;
                else if (opcode == OPC_MOVE && op == OP_MOVR)
                    next_state = st_getb;
                else if (opcode == OPC_ALU && op == OP_MVN)
                    next_state = st_getb;
                else if (opcode == OPC_ALU)
                    next_state = st_geta;
                else
                    next_state = st_wait;
            end
            st_geta: begin
                next_state = st_getb;
            end
            st_getb: begin
                if (opcode == OPC_ALU && (op == OP_ADD || op == OP_AND))
                    next_state = st_and_add;
                else if (opcode == OPC_ALU && op == OP_CMP)
                    next_state = st_getstatus;
                else
                    next_state = st_mvn_mov;
            end
            st_and_add:      next_state = st_result_to_rd;
            st_mvn_mov:      next_state = st_result_to_rd;
            st_getstatus:    next_state = st_wait;
            st_result_to_rd: next_state = st_wait;
            st_movim_to_rn:  next_state = st_wait;
            default:         next_state = st_wait;
        endcase
    end

    // State register plus registered strobes for the state being entered;
    // reset aborts any instruction immediately, dropping a pending write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            present_state <= st_wait;
            ctrl          <= ctrl_of(st_wait);
        end else begin
            present_state <= next_state;
            ctrl          <= ctrl_of(next_state);
        end
    end

    assign vsel  = ctrl.vsel;
    assign write = ctrl.write;
    assign loada = ctrl.loada;
    assign loadb = ctrl.loadb;
    assign asel  = ctrl.asel;
    assign bsel  = ctrl.bsel;
    assign loadc = ctrl.loadc;
    assign loads = ctrl.loads;
    assign nsel  = ctrl.nsel;
    assign w     = ctrl.w;

endmodule

// File: tb/tb_control.sv
// tb_control: directed and randomized instruction sequences for the control FSM,
// checked against an instruction-level reference model (state walk, strobes,
// write/status counts, and edges until idle).
`timescale 1ns/1ps
module tb_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s = 1'b0;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       asel;
    logic       bsel;
    logic       loadc;
    logic       loads;
    logic [2:0] nsel;
    logic       w;

    logic [13:0] obs;
    int checks = 0;
    int errors = 0;

    int exp_seq[$];
    int exp_edges;
    int exp_writes;
    int exp_loads;

    control dut (
        .clk    (clk),
        .reset  (reset),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .vsel   (vsel),
        .write  (write),
        .loada  (loada),
        .loadb  (loadb),
        .asel   (asel),
        .bsel   (bsel),
        .loadc  (loadc),
        .loads  (loads),
        .nsel   (nsel),
        .w      (w)
    );

    always #5 clk = ~clk;

    assign obs = {vsel, write, loada, loadb, asel, bsel, loadc, loads, nsel, w};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected strobes for a state number, packed as {vsel,write,loada,loadb,asel,bsel,loadc,loads,nsel,w}.
    function automatic logic [13:0] exp_out(input int st);
        logic [1:0] v;
        logic       wr, la, lb, as, bs, lc, ls, ww;
        logic [2:0] ns;
        v = 2'b00; wr = 0; la = 0; lb = 0; as = 0; bs = 0; lc = 0; ls = 0; ww = 0; ns = 3'b000;
        case (st)
            0: ww = 1;
            3: begin ns = 3'b100; la = 1; end
            2: begin ns = 3'b001; lb = 1; end
            4: lc = 1;
            5: begin as = 1; lc = 1; end
            6: ls = 1;
            7: begin ns = 3'b010; v = 2'b00; wr = 1; end
            8: begin ns = 3'b100; v = 2'b10; wr = 1; end
            default: ;
        endcase
        return {v, wr, la, lb, as, bs, lc, ls, ns, ww};
    endfunction

    // Instruction-level model: states visited after the start edge, edges until
    // idle again, and how many write / status-load cycles the instruction makes.
    task automatic model(input logic [2:0] opc, input logic [1:0] o);
        if (opc == 3'b101 && (o == 2'b00 || o == 2'b10)) begin
            exp_seq = '{1, 3, 2, 4, 7}; exp_edges = 5; exp_writes = 1; exp_loads = 0;
        end else if (opc == 3'b101 && o == 2'b01) begin
            exp_seq = '{1, 3, 2, 6};    exp_edges = 4; exp_writes = 0; exp_loads = 1;
        end else if ((opc == 3'b101 && o == 2'b11) || (opc == 3'b110 && o == 2'b00)) begin
            exp_seq = '{1, 2, 5, 7};    exp_edges = 4; exp_writes = 1; exp_loads = 0;
        end else if (opc == 3'b110 && o == 2'b10) begin
            exp_seq = '{1, 8};          exp_edges = 2; exp_writes = 1; exp_loads = 0;
        end else begin
            // undefined encodings fall from decode straight back to idle
            exp_seq = '{1};             exp_edges = 1; exp_writes = 0; exp_loads = 0;
        end
    endtask

    task automatic run_instr(input string tag, input logic [2:0] opc, input logic [1:0] o, input bit hold);
        int edges;
        int n_write;
        int n_loads;
        int idx;
        model(opc, o);
        check({tag, "/idle_state"}, dut.present_state, 0);
        check({tag, "/idle_out"}, obs, exp_out(0));
        opcode = opc;
        op = o;
        s = 1'b1;
        @(posedge clk); #1;
        if (!hold) s = 1'b0;
        edges = 0; n_write = 0; n_loads = 0; idx = 0;
        while (w !== 1'b1 && edges < 12) begin
            if (idx < exp_seq.size()) begin
                check({tag, "/state"}, dut.present_state, exp_seq[idx]);
                check({tag, "/out"}, obs, exp_out(exp_seq[idx]));
            end else begin
                check({tag, "/overrun_state"}, dut.present_state, 0);
            end
            n_write += int'(write);
            n_loads += int'(loads);
            idx++;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "/edges_to_idle"}, edges, exp_edges);
        check({tag, "/write_cycles"}, n_write, exp_writes);
        check({tag, "/loads_cycles"}, n_loads, exp_loads);
        check({tag, "/end_state"}, dut.present_state, 0);
    endtask

    initial begin
        // reset held low over a few edges
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset/state", dut.present_state, 0);
        check("reset/out", obs, exp_out(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset/state", dut.present_state, 0);
        check("post_reset/w", w, 1'b1);

        // directed instructions
        run_instr("add",   3'b101, 2'b00, 1'b0);
        run_instr("movim", 3'b110, 2'b10, 1'b0);
        run_instr("mvn",   3'b101, 2'b11, 1'b0);
        run_instr("movr",  3'b110, 2'b00, 1'b0);
        run_instr("cmp",   3'b101, 2'b01, 1'b0);
        run_instr("and",   3'b101, 2'b10, 1'b0);
        run_instr("undef0", 3'b000, 2'b00, 1'b0);
        run_instr("undef1", 3'b110, 2'b01, 1'b0);
        run_instr("undef2", 3'b110, 2'b11, 1'b0);

        // s ignored while idle-low: no start without s
        repeat (3) @(posedge clk);
        #1;
        check("no_start/state", dut.present_state, 0);

        // randomized instruction stream, sometimes with s held high
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ropc;
            logic [1:0] rop;
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) ropc = 3'($urandom_range(0, 7));
            else if (r == 1) ropc = 3'b110;
            else ropc = 3'b101;
            rop = 2'($urandom_range(0, 3));
            run_instr("rand", ropc, rop, 1'($urandom_range(0, 1)));
        end

        // back-to-back with s held high: each idle cycle immediately restarts
        run_instr("b2b_movim", 3'b110, 2'b10, 1'b1);
        run_instr("b2b_add",   3'b101, 2'b00, 1'b1);
        run_instr("b2b_cmp",   3'b101, 2'b01, 1'b0);

        // asynchronous reset while in GetB aborts the ADD with no write
        opcode = 3'b101;
        op = 2'b00;
        s = 1'b1;
        @(posedge clk); #1;
        s = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midreset/in_getb", dut.present_state, 2);
        #1;
        reset = 1'b0;
        #1;
        check("midreset/state_async", dut.present_state, 0);
        check("midreset/w_async", w, 1'b1);
        check("midreset/out_async", obs, exp_out(0));
        @(posedge clk); #1;
        check("midreset/held_state", dut.present_state, 0);
        check("midreset/no_write", write, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset/release", dut.present_state, 0);
        run_instr("after_reset_mvn", 3'b101, 2'b11, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
